serial_compare_ctrl: RTL and testbench
======================================

SERIAL_COMPARE_CTRL -- requirements
Module: serial_compare_ctrl

Interface
REQ-001 Parameter WIDTH, default 16, operand width in bits; it SHALL be even and at least 2.
REQ-002 Parameter EARLY_EXIT, default 1; 1 means stop at the first unequal digit, 0 means always scan every digit (constant latency).
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operand pair a/b is valid.
REQ-006 in_ready  output  1  block accepts operands; a transfer occurs on any edge where in_valid and in_ready are both 1.
REQ-007 a, b  input  WIDTH each  unsigned operands, sampled only on an input transfer.
REQ-008 out_valid  output  1  result valid.
REQ-009 out_ready  input  1  consumer accepts the result; a transfer occurs on any edge where out_valid and out_ready are both 1.
REQ-010 gt, eq, lt  output  1 each  a>b, a==b, a<b.

Function
REQ-011 The block SHALL compare operands serially, MSB digit first, in 2-bit digits (WIDTH/2 digits), using one 2-bit comparator instance per cycle.
REQ-012 FSM states SHALL be IDLE, SCAN and DONE; no other states are reachable.
REQ-013 IDLE: in_ready=1. On an input transfer, the block SHALL load a and b into shift registers, set the digit index to WIDTH/2-1, clear the sticky result, and go to SCAN.
REQ-014 SCAN: in_ready=0. The comparator inputs SHALL be the top 2 bits of each shift register.
REQ-015 SCAN with EARLY_EXIT=1, comparator G or L: latch gt/lt accordingly and go to DONE.
REQ-016 SCAN with EARLY_EXIT=0: the first unequal digit SHALL set a sticky gt/lt that later digits never overwrite; scanning continues.
REQ-017 SCAN with index==0 and no sticky or early result: set eq=1 and go to DONE. Otherwise at index==0, go to DONE with the sticky result.
REQ-018 SCAN with scanning continuing: shift both registers left by 2 and decrement the index.
REQ-019 DONE: out_valid=1 and in_ready=0. gt/eq/lt SHALL hold stable until an output transfer, then the block goes to IDLE.
REQ-020 Latency: out_valid SHALL rise k edges after the input-transfer edge.
  - EARLY_EXIT=1: k is the 1-based position of the first differing digit from the MSB, or WIDTH/2 if the operands are equal.
  - EARLY_EXIT=0: k=WIDTH/2 always.
REQ-021 When out_valid=1, exactly one of gt/eq/lt SHALL be 1. When out_valid=0, all three SHALL be 0.
REQ-022 in_valid while not in IDLE SHALL be ignored, and a/b changes SHALL not affect an operation in flight. The next input is accepted no earlier than the cycle after an output transfer.

Reset
REQ-023 While rst=1 in any state, the next edge SHALL force IDLE and abandon any in-flight operation without producing a result.
REQ-024 Reset values: out_valid=0, gt=eq=lt=0, shift registers and index 0. in_ready SHALL be 0 while rst=1 and 1 in the first cycle after rst deasserts.

Structure
REQ-025 State encodings and the digit width constant (2) SHALL live in a shared include file, compare_defs.vh.
REQ-026 The 2-bit digit comparison SHALL be the existing comparator sub-module (ports A, B, G, E, L), instantiated once. The controller itself contains no magnitude logic.

Verification (WIDTH=16)
REQ-027 EARLY_EXIT=1, a=16'hC000, b=16'h4000 -> gt=1, out_valid 1 edge after accept.
REQ-028 EARLY_EXIT=1, a=b=16'hA5A5 -> eq=1, out_valid 8 edges after accept.
REQ-029 EARLY_EXIT=1, a=16'h0001, b=16'h0002 -> lt=1 after 8 edges.
REQ-030 EARLY_EXIT=0, a=16'hC001, b=16'h4003 -> gt=1 (not lt) after exactly 8 edges.
REQ-031 Result pending, out_ready=0 for 5 cycles, in_valid=1 with new operands -> gt/eq/lt stable, in_ready=0, new operands not accepted. After out_ready=1 -> IDLE, and the next operands are accepted.
REQ-032 rst pulsed for 1 cycle mid-SCAN -> next cycle IDLE, out_valid=0, in_ready=1, and no result is ever emitted for the aborted pair.

Source files
------------

// File: rtl/serial_compare_ctrl_pkg.sv
// Shared definitions for the serial magnitude comparator: FSM encoding and digit width.
package serial_compare_ctrl_pkg;

   localparam int unsigned DIGIT_W = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/serial_compare_ctrl_cmp2.sv
// Single-digit magnitude comparator; exactly one of G/E/L is high.
module serial_compare_ctrl_cmp2
   import serial_compare_ctrl_pkg::*;
(
   input  logic [DIGIT_W-1:0] A,
   input  logic [DIGIT_W-1:0] B,
   output logic               G,
   output logic               E,
   output logic               L
);

   assign G = (A > B);
   assign E = (A == B);
   assign L = (A < B);

endmodule

// File: rtl/serial_compare_ctrl.sv
// Serial unsigned comparator: scans 2-bit digits MSB first with one shared digit comparator,
// optionally stopping at the first unequal digit.
module serial_compare_ctrl
   import serial_compare_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH      = 16,
   parameter int unsigned EARLY_EXIT = 1
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             gt,
   output logic             eq,
   output logic             lt
);

   localparam int unsigned DIGITS = WIDTH / DIGIT_W;
   localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

   state_e           state_q;
   logic [WIDTH-1:0] a_q, b_q;
   logic [IDX_W-1:0] idx_q;
   logic             sticky_gt_q, sticky_lt_q;
   logic             out_valid_q, gt_q, eq_q, lt_q;

   logic cmp_g, cmp_e, cmp_l;
   logic res_gt, res_lt, res_eq, scan_done;

   serial_compare_ctrl_cmp2 u_cmp (
      .A (a_q[WIDTH-1 -: DIGIT_W]),
      .B (b_q[WIDTH-1 -: DIGIT_W]),
      .G (cmp_g),
      .E (cmp_e),
      .L (cmp_l)
   );

   // An earlier unequal digit always wins over the current one.
   assign res_gt    = sticky_gt_q | (~sticky_lt_q & cmp_g);
   assign res_lt    = sticky_lt_q | (~sticky_gt_q & cmp_l);
   assign res_eq    = ~sticky_gt_q & ~sticky_lt_q & cmp_e;
   assign scan_done = (idx_q == '0) || ((EARLY_EXIT != 0) && (cmp_g || cmp_l));

   // Ready is gated by reset so it is low during reset and high right after release.
   assign in_ready  = (state_q == ST_IDLE) && !rst;
   assign out_valid = out_valid_q;
   assign gt        = gt_q;
   assign eq        = eq_q;
   assign lt        = lt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         a_q         <= '0;
         b_q         <= '0;
         idx_q       <= '0;
         sticky_gt_q <= 1'b0;
         sticky_lt_q <= 1'b0;
         out_valid_q <= 1'b0;
         gt_q        <= 1'b0;
         eq_q        <= 1'b0;
         lt_q        <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid) begin
                  a_q         <= a;
                  b_q         <= b;
                  idx_q       <= IDX_LAST;
                  sticky_gt_q <= 1'b0;
                  sticky_lt_q <= 1'b0;
                  state_q     <= ST_SCAN;
               end
            end
            ST_SCAN: begin
               if (scan_done) begin
                  gt_q        <= res_gt;
                  eq_q        <= res_eq;
                  lt_q        <= res_lt;
                  out_valid_q <= 1'b1;
                  state_q     <= ST_DONE;
               end else begin
                  sticky_gt_q <= res_gt;
                  sticky_lt_q <= res_lt;
                  a_q         <= a_q << DIGIT_W;
                  b_q         <= b_q << DIGIT_W;
                  idx_q       <= idx_q - IDX_W'(1);
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  gt_q        <= 1'b0;
                  eq_q        <= 1'b0;
                  lt_q        <= 1'b0;
                  state_q     <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Directed bench: early-exit and constant-latency instances driven with the same stimulus.
module tb_serial_compare_ctrl;

   localparam int unsigned WIDTH = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             out_ready;
   logic [WIDTH-1:0] a, b;
   logic             in_ready_e, out_valid_e, gt_e, eq_e, lt_e;
   logic             in_ready_c, out_valid_c, gt_c, eq_c, lt_c;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   serial_compare_ctrl #(.WIDTH(WIDTH), .EARLY_EXIT(1)) dut_e (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_e),
      .a(a), .b(b), .out_valid(out_valid_e), .out_ready(out_ready),
      .gt(gt_e), .eq(eq_e), .lt(lt_e)
   );

   serial_compare_ctrl #(.WIDTH(WIDTH), .EARLY_EXIT(0)) dut_c (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_c),
      .a(a), .b(b), .out_valid(out_valid_c), .out_ready(out_ready),
      .gt(gt_c), .eq(eq_c), .lt(lt_c)
   );

   typedef struct {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [2:0]       res;   // {gt, eq, lt}
      int               k_e;   // early-exit latency in edges
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Presents an operand pair, then scrambles the inputs while the pair is in flight.
   task automatic launch(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb);
      chk("in_ready_e_idle", 32'(in_ready_e), 32'd1);
      chk("in_ready_c_idle", 32'(in_ready_c), 32'd1);
      in_valid = 1'b1;
      a        = va;
      b        = vb;
      step();
      in_valid = 1'b0;
      a        = WIDTH'($urandom);
      b        = WIDTH'($urandom);
   endtask

   // Waits (bounded) for both results; returns the edge count for each instance.
   task automatic wait_both(output int k_e, output int k_c);
      k_e = 0;
      k_c = 0;
      for (int e = 1; e <= 20; e++) begin
         step();
         if (e == 1) chk("scan_quiet_c", 32'({out_valid_c, gt_c, eq_c, lt_c}), 32'd0);
         if (out_valid_e && k_e == 0) k_e = e;
         if (out_valid_c && k_c == 0) k_c = e;
         if (k_e != 0 && k_c != 0) break;
      end
   endtask

   task automatic release_out();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("out_valid_e_after_xfer", 32'(out_valid_e), 32'd0);
      chk("out_valid_c_after_xfer", 32'(out_valid_c), 32'd0);
      chk("flags_e_after_xfer", 32'({gt_e, eq_e, lt_e}), 32'd0);
   endtask

   task automatic run(input vec_t v);
      int k_e, k_c;
      launch(v.a, v.b);
      wait_both(k_e, k_c);
      chk("latency_e", 32'(k_e), 32'(v.k_e));
      chk("latency_c", 32'(k_c), 32'd8);
      chk("result_e", 32'({gt_e, eq_e, lt_e}), 32'(v.res));
      chk("result_c", 32'({gt_c, eq_c, lt_c}), 32'(v.res));
      release_out();
   endtask

   initial begin
      int k_e, k_c;
      int seen;

      vecs[0] = '{16'hC000, 16'h4000, 3'b100, 1};
      vecs[1] = '{16'hA5A5, 16'hA5A5, 3'b010, 8};
      vecs[2] = '{16'h0001, 16'h0002, 3'b001, 8};
      vecs[3] = '{16'hC001, 16'h4003, 3'b100, 1};
      vecs[4] = '{16'h1234, 16'h1244, 3'b001, 5};
      vecs[5] = '{16'hFFFF, 16'h0000, 3'b100, 1};
      vecs[6] = '{16'h0000, 16'h0000, 3'b010, 8};
      vecs[7] = '{16'h8000, 16'h7FFF, 3'b100, 1};
      vecs[8] = '{16'h00FF, 16'h0100, 3'b001, 4};

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = '0;
      b         = '0;
      repeat (3) step();
      chk("in_ready_in_reset", 32'({in_ready_e, in_ready_c}), 32'd0);
      chk("reset_outputs_e", 32'({out_valid_e, gt_e, eq_e, lt_e}), 32'd0);
      chk("reset_outputs_c", 32'({out_valid_c, gt_c, eq_c, lt_c}), 32'd0);
      rst = 1'b0;
      #1;
      chk("in_ready_after_reset", 32'({in_ready_e, in_ready_c}), 32'd3);
      step();

      for (int i = 0; i < 9; i++) run(vecs[i]);

      // Backpressure: result held, new operands refused until the output transfer.
      launch(16'hC000, 16'h4000);
      wait_both(k_e, k_c);
      chk("bp_latency_c", 32'(k_c), 32'd8);
      in_valid = 1'b1;
      a        = 16'h0001;
      b        = 16'h0002;
      for (int i = 0; i < 5; i++) begin
         chk("bp_hold_e", 32'({out_valid_e, gt_e, eq_e, lt_e, in_ready_e}), 32'b11000);
         chk("bp_hold_c", 32'({out_valid_c, gt_c, eq_c, lt_c, in_ready_c}), 32'b11000);
         step();
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      in_valid  = 1'b0;
      chk("bp_idle_e", 32'({out_valid_e, in_ready_e}), 32'b01);
      chk("bp_idle_c", 32'({out_valid_c, in_ready_c}), 32'b01);
      run('{16'h0001, 16'h0002, 3'b001, 8});

      // Reset mid-scan: the aborted pair must never produce a result.
      launch(16'h0001, 16'h0002);
      repeat (3) step();
      rst = 1'b1;
      #1;
      chk("in_ready_rst_pulse", 32'({in_ready_e, in_ready_c}), 32'd0);
      step();
      rst = 1'b0;
      #1;
      chk("abort_state_e", 32'({out_valid_e, in_ready_e}), 32'b01);
      chk("abort_state_c", 32'({out_valid_c, in_ready_c}), 32'b01);
      seen = 0;
      for (int i = 0; i < 15; i++) begin
         step();
         if (out_valid_e || out_valid_c) seen++;
      end
      chk("abort_no_result", 32'(seen), 32'd0);
      run('{16'h00FF, 16'h0100, 3'b001, 4});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
